// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg : shared widths, FSM encoding and read-latency bounds for mem_responder
// Revision: 1.0
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 16;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sp_ram : single-port synchronous RAM, write on edge, registered read, no reset
// Revision: 1.0
// ---------------------------------------------------------------------------
module sp_ram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] ram_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Read returns the pre-write contents; CPU requests never read and write together.
  always_ff @(posedge clk) begin
    if (we) begin
      ram_q[addr] <= wdata;
    end
    rdata_q <= ram_q[addr];
  end

  assign rdata = rdata_q;

endmodule : sp_ram
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_responder : boot-loaded 2^ADDR_W x DATA_W store serving CPU requests
//                 with a fixed, fully pipelined read latency
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  input  logic              boot_last,
  output logic              boot_ready,
  output logic              cpu_hold,
  output logic              err
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                boot_ready_q, boot_ready_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                err_q, err_d;
  logic                dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [READ_LAT-1:0] vld_q, vld_d;

  logic                w_run;
  logic                w_boot_acc;
  logic                w_issue;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]   w_ram_rdata;
  logic [DATA_W-1:0]   w_rd_tap;

  assign w_run      = (state_q == ST_RUN);
  assign w_boot_acc = !w_run && boot_valid;
  assign w_issue    = w_run && mem_en && mem_read && !mem_write;

  // The single RAM port belongs to the boot loader until RUN, then to the CPU.
  assign w_ram_we    = w_run ? (mem_en && mem_write) : w_boot_acc;
  assign w_ram_addr  = w_run ? addr : ptr_q;
  assign w_ram_wdata = w_run ? din  : boot_data;

  sp_ram #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  // The RAM output register is the first latency stage; extra stages follow it.
  generate
    if (READ_LAT == 1) begin : g_lat1
      assign w_rd_tap = w_ram_rdata;
    end else begin : g_latn
      logic [DATA_W-1:0] data_q [READ_LAT-1];
      logic [DATA_W-1:0] data_d [READ_LAT-1];

      always_comb begin
        data_d[0] = w_ram_rdata;
        for (int k = 1; k < READ_LAT - 1; k++) begin
          data_d[k] = data_q[k-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < READ_LAT - 1; k++) begin
            data_q[k] <= '0;
          end
        end else begin
          data_q <= data_d;
        end
      end

      assign w_rd_tap = data_q[READ_LAT-2];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (w_boot_acc) begin
      if (!(&ptr_q)) begin
        ptr_d = ptr_q + 1'b1;
      end
      if (boot_last || (&ptr_q)) begin
        state_d = ST_RUN;
      end
    end

    boot_ready_d = (state_d == ST_BOOT);
    cpu_hold_d   = (state_d == ST_BOOT);
    err_d        = mem_en && (!w_run || (mem_read && mem_write));

    vld_d[0] = w_issue;
    for (int k = 1; k < READ_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
    end

    dout_valid_d = vld_q[READ_LAT-1];
    dout_d       = vld_q[READ_LAT-1] ? w_rd_tap : dout_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      ptr_q        <= '0;
      boot_ready_q <= 1'b1;
      cpu_hold_q   <= 1'b1;
      err_q        <= 1'b0;
      vld_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      boot_ready_q <= boot_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      err_q        <= err_d;
      vld_q        <= vld_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign boot_ready = boot_ready_q;
  assign cpu_hold   = cpu_hold_q;
  assign err        = err_q;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_responder : directed bench driving READ_LAT=1 and READ_LAT=3 instances
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        mem_en, mem_read, mem_write;
  logic [11:0] addr;
  logic [15:0] din;
  logic        boot_valid, boot_last;
  logic [15:0] boot_data;

  logic [15:0] dout1, dout3;
  logic        dv1, dv3, br1, br3, ch1, ch3, err1, err3;

  int tests;
  int fails;

  mem_responder #(.ADDR_W(12), .DATA_W(16), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .din(din), .dout(dout1),
    .dout_valid(dv1), .boot_valid(boot_valid), .boot_data(boot_data),
    .boot_last(boot_last), .boot_ready(br1), .cpu_hold(ch1), .err(err1)
  );

  mem_responder #(.ADDR_W(12), .DATA_W(16), .READ_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .din(din), .dout(dout3),
    .dout_valid(dv3), .boot_valid(boot_valid), .boot_data(boot_data),
    .boot_last(boot_last), .boot_ready(br3), .cpu_hold(ch3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, rd, wr;
    logic [11:0] a;
    logic [15:0] d;
    logic        dv1;
    logic [15:0] o1;
    logic        dv3;
    logic [15:0] o3;
    logic        er;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic en, input logic rd, input logic wr,
                              input logic [11:0] a, input logic [15:0] d,
                              input logic v1, input logic [15:0] o1,
                              input logic v3, input logic [15:0] o3,
                              input logic er);
    vec_t v;
    v.en = en; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
    v.dv1 = v1; v.o1 = o1; v.dv3 = v3; v.o3 = o3; v.er = er;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dout1"}, dout1, 16'h0);
    chk({tag, " dout3"}, dout3, 16'h0);
    chk({tag, " dv1"}, {15'h0, dv1}, 16'h0);
    chk({tag, " dv3"}, {15'h0, dv3}, 16'h0);
    chk({tag, " br1"}, {15'h0, br1}, 16'h1);
    chk({tag, " br3"}, {15'h0, br3}, 16'h1);
    chk({tag, " ch3"}, {15'h0, ch3}, 16'h1);
    chk({tag, " err3"}, {15'h0, err3}, 16'h0);
  endtask

  task automatic boot_word(input logic [15:0] d, input logic last);
    boot_valid = 1'b1;
    boot_data  = d;
    boot_last  = last;
    tick();
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic cpu_read(input logic [11:0] a);
    mem_en = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = a;
  endtask

  task automatic cpu_idle;
    mem_en = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  logic [15:0] boot6 [6];
  logic [15:0] exp3  [3];

  initial begin
    tests = 0;
    fails = 0;
    boot6[0] = 16'hb081; boot6[1] = 16'haf00; boot6[2] = 16'h1c3a;
    boot6[3] = 16'h2300; boot6[4] = 16'hddf6; boot6[5] = 16'he004;

    vt[0]  = mk(1, 1, 0, 12'h000, 16'h0,    0, 16'h0000, 0, 16'h0000, 0);
    vt[1]  = mk(1, 1, 0, 12'h001, 16'h0,    1, 16'hb081, 0, 16'h0000, 0);
    vt[2]  = mk(1, 1, 0, 12'h002, 16'h0,    1, 16'haf00, 0, 16'h0000, 0);
    vt[3]  = mk(1, 1, 0, 12'h003, 16'h0,    1, 16'h1c3a, 1, 16'hb081, 0);
    vt[4]  = mk(0, 0, 0, 12'h000, 16'h0,    1, 16'h2300, 1, 16'haf00, 0);
    vt[5]  = mk(0, 0, 0, 12'h000, 16'h0,    0, 16'h2300, 1, 16'h1c3a, 0);
    vt[6]  = mk(1, 0, 1, 12'h0ff, 16'h1234, 0, 16'h2300, 1, 16'h2300, 0);
    vt[7]  = mk(1, 1, 0, 12'h0ff, 16'h0,    0, 16'h2300, 0, 16'h2300, 0);
    vt[8]  = mk(1, 0, 0, 12'h004, 16'h0,    1, 16'h1234, 0, 16'h2300, 0);
    vt[9]  = mk(1, 1, 1, 12'h010, 16'hbeef, 0, 16'h1234, 0, 16'h2300, 1);
    vt[10] = mk(0, 0, 0, 12'h000, 16'h0,    0, 16'h1234, 1, 16'h1234, 0);
    vt[11] = mk(1, 1, 0, 12'h010, 16'h0,    0, 16'h1234, 0, 16'h1234, 0);
    vt[12] = mk(1, 1, 0, 12'h004, 16'h0,    1, 16'hbeef, 0, 16'h1234, 0);
    vt[13] = mk(1, 1, 0, 12'h005, 16'h0,    1, 16'hddf6, 0, 16'h1234, 0);
    vt[14] = mk(0, 0, 0, 12'h000, 16'h0,    1, 16'he004, 1, 16'hbeef, 0);
    vt[15] = mk(0, 0, 0, 12'h000, 16'h0,    0, 16'he004, 1, 16'hddf6, 0);
    vt[16] = mk(0, 0, 0, 12'h000, 16'h0,    0, 16'he004, 1, 16'he004, 0);
    vt[17] = mk(0, 0, 0, 12'h000, 16'h0,    0, 16'he004, 0, 16'he004, 0);

    reset = 1'b1;
    cpu_idle();
    addr = '0; din = '0;
    boot_valid = 1'b0; boot_last = 1'b0; boot_data = '0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Request during BOOT: err only, no read, pointer untouched
    cpu_read(12'h000);
    tick();
    chk("boot_rd err3", {15'h0, err3}, 16'h1);
    chk("boot_rd err1", {15'h0, err1}, 16'h1);
    cpu_idle();
    tick();
    chk("boot_rd err clr", {15'h0, err3}, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("boot_rd dv1", {15'h0, dv1}, 16'h0);
      chk("boot_rd dv3", {15'h0, dv3}, 16'h0);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      boot_word(boot6[i], i == 5);
      chk("boot6 br3", {15'h0, br3}, (i == 5) ? 16'h0 : 16'h1);
      chk("boot6 ch3", {15'h0, ch3}, (i == 5) ? 16'h0 : 16'h1);
    end
    chk("boot6 br1", {15'h0, br1}, 16'h0);

    // RUN table; boot stream held active to show it is ignored
    boot_valid = 1'b1; boot_last = 1'b1; boot_data = 16'hffff;
    for (int i = 0; i < 18; i++) begin
      mem_en = vt[i].en; mem_read = vt[i].rd; mem_write = vt[i].wr;
      addr = vt[i].a; din = vt[i].d;
      tick();
      chk($sformatf("vec%0d dv1", i), {15'h0, dv1}, {15'h0, vt[i].dv1});
      chk($sformatf("vec%0d dout1", i), dout1, vt[i].o1);
      chk($sformatf("vec%0d dv3", i), {15'h0, dv3}, {15'h0, vt[i].dv3});
      chk($sformatf("vec%0d dout3", i), dout3, vt[i].o3);
      chk($sformatf("vec%0d err3", i), {15'h0, err3}, {15'h0, vt[i].er});
      chk($sformatf("vec%0d br3", i), {15'h0, br3}, 16'h0);
    end
    boot_valid = 1'b0; boot_last = 1'b0;
    cpu_idle();

    // Async reset with a read in flight
    cpu_read(12'h001);
    tick();
    cpu_idle();
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst dv3", {15'h0, dv3}, 16'h0);
      chk("post_rst dv1", {15'h0, dv1}, 16'h0);
    end

    // Partial boot, reset, then shorter reboot
    boot_word(16'h1111, 1'b0);
    boot_word(16'h2222, 1'b0);
    boot_word(16'h3333, 1'b0);
    chk("partial br3", {15'h0, br3}, 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    boot_word(16'haaaa, 1'b0);
    boot_word(16'hbbbb, 1'b1);
    chk("reboot br3", {15'h0, br3}, 16'h0);
    exp3[0] = 16'haaaa; exp3[1] = 16'hbbbb; exp3[2] = 16'h3333;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) cpu_read(i[11:0]); else cpu_idle();
      tick();
      if (i >= 1 && i <= 3) chk($sformatf("reboot rd1 a%0d", i - 1), dout1, exp3[i-1]);
      if (i >= 3) chk($sformatf("reboot rd3 a%0d", i - 3), dout3, exp3[i-3]);
    end

    // Full-depth boot with no boot_last
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      boot_valid = 1'b1;
      boot_data  = 16'(i) ^ 16'hc3c3;
      boot_last  = 1'b0;
      tick();
      if (i == 4094) chk("full br3 pre", {15'h0, br3}, 16'h1);
    end
    chk("full br3", {15'h0, br3}, 16'h0);
    chk("full ch3", {15'h0, ch3}, 16'h0);
    boot_data = 16'h0000;
    tick();
    boot_valid = 1'b0;
    chk("full extra br3", {15'h0, br3}, 16'h0);
    cpu_read(12'h000);
    tick();
    cpu_read(12'hfff);
    tick();
    chk("full rd a000", dout1, 16'hc3c3);
    cpu_idle();
    tick();
    chk("full rd afff", dout1, 16'hcc3c);
    chk("full rd dv1", {15'h0, dv1}, 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_responder
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the 16-bit CPU's memory port: a 4096 x 16 word store answering the CPU's mem_en/mem_read/mem_write requests with a programmable read latency. A boot-load front end fills memory from address 0 over a valid/ready stream while holding the CPU in stall, then hands the port to the CPU. Sits between the CPU's addr/dout/din pins and the program-load source in the top-level and in simulation.

## Interface
- ADDR_W, 12, word address width
- DATA_W, 16, data word width
- READ_LAT, 1, read latency in cycles, legal 1..4
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_en  in  1  CPU request strobe
- mem_read  in  1  read request, qualified by mem_en
- mem_write  in  1  write request, qualified by mem_en
- addr  in  ADDR_W  CPU word address
- din  in  DATA_W  write data from CPU
- dout  out  DATA_W  read data to CPU
- dout_valid  out  1  one-cycle pulse, dout carries a fresh read result
- boot_valid  in  1  boot word present
- boot_data  in  DATA_W  boot word
- boot_last  in  1  final boot word, qualified by boot_valid
- boot_ready  out  1  boot word accepted this cycle when high with boot_valid
- cpu_hold  out  1  CPU must stall and issue no requests
- err  out  1  one-cycle pulse on illegal request

## Operation
- States: BOOT, RUN. Reset enters BOOT.
- BOOT: boot_ready=1, cpu_hold=1. On boot_valid && boot_ready: mem[ptr] <= boot_data, ptr <= ptr+1. Transition to RUN after the accept carrying boot_last, or after accepting at ptr = 2^ADDR_W-1 (no wrap; further words not taken).
- BOOT: any mem_en ignored (no write, no dout_valid), err pulses.
- RUN: boot_ready=0, cpu_hold=0; boot inputs ignored. No path back to BOOT except reset.
- Write: mem_en && mem_write && !mem_read -> mem[addr] <= din at that edge.
- Read: mem_en && mem_read && !mem_write -> request enters a READ_LAT-deep pipeline carrying the data read at the issue edge; result appears on dout with dout_valid exactly READ_LAT cycles after issue. One new read per cycle; reads fully pipelined.
- mem_read && mem_write together with mem_en: write performed, no read issued, err pulses.
- mem_en with neither read nor write: no action, no err.
- dout holds its last value between reads; dout_valid low otherwise.
- Same-address write then read in the next cycle returns the new data. Read issued in the same cycle as the write to that address is impossible (requests are exclusive).
- Memory array contents are not cleared by reset; only control state is.

## Timing
- Reset values: dout=0, dout_valid=0, boot_ready=1, cpu_hold=1, err=0, ptr=0, read pipeline empty.
- Reset mid-boot: ptr returns to 0; already-written words stay in the array and may be overwritten.
- Reset mid-read: in-flight reads dropped, no dout_valid after reset releases.
- BOOT->RUN: the boot_last accept edge sets state RUN; cpu_hold falls in the same cycle boot_ready falls (cycle after the accept).
- err is registered: high the cycle after the offending request.
- READ_LAT=1: dout/dout_valid update on the edge following the issue edge.

## Structure
- Shared package mem_pkg: ADDR_W/DATA_W defaults, state encoding (BOOT=0, RUN=1), READ_LAT bounds.
- One sub-module: sp_ram (single-port synchronous RAM, write on edge, registered read, no reset); mem_responder holds FSM, boot pointer, read-latency shift pipeline, err logic.

## Test plan
- Boot 6 words 16'hb081, 16'haf00, 16'h1c3a, 16'h2300, 16'hddf6, 16'he004 (last on word 6) -> boot_ready drops and cpu_hold falls the cycle after word 6; reads of addr 0..5 return those words in order.
- READ_LAT=3, back-to-back reads addr 1,2,3 in RUN -> dout_valid high three consecutive cycles starting 3 cycles after first issue, dout = 16'haf00, 16'h1c3a, 16'h2300.
- Write 16'h1234 to addr 12'h0ff, read addr 12'h0ff next cycle -> dout=16'h1234, dout_valid one pulse.
- mem_en with mem_read=mem_write=1 at addr 12'h010, din 16'hbeef -> err pulse one cycle later, no dout_valid, later read of 12'h010 returns 16'hbeef.
- mem_en read during BOOT -> no dout_valid, err pulse, ptr unchanged; boot of 4096 words without boot_last -> RUN after word 4096, boot_ready=0.
- Reset asserted after 3 boot words and during an in-flight read -> all outputs at reset values, ptr=0, no stray dout_valid; reboot with 2 words overwrites addr 0..1, addr 2 keeps old content.
